// File: rtl/mor1kx_tlb_reload_bridge_if.sv
// MMU reload client handshakes and Wishbone master signals of the TLB reload bridge.
// The master modport is the bridge side; the slave modport is the clients plus bus slave.
interface mor1kx_tlb_reload_bridge_if #(
   parameter int unsigned OPTION_OPERAND_WIDTH = 32
);
   logic                            dmmu_req_i;
   logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i;
   logic                            dmmu_ack_o;
   logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o;
   logic                            immu_req_i;
   logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i;
   logic                            immu_ack_o;
   logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o;
   logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o;
   logic                            wbm_cyc_o;
   logic                            wbm_stb_o;
   logic                            wbm_we_o;
   logic [3:0]                      wbm_sel_o;
   logic [2:0]                      wbm_cti_o;
   logic [1:0]                      wbm_bte_o;
   logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i;
   logic                            wbm_ack_i;
   logic                            wbm_err_i;
   logic                            busy_o;
   logic                            bus_err_o;

   modport master (
      input  dmmu_req_i, dmmu_addr_i, immu_req_i, immu_addr_i,
      input  wbm_dat_i, wbm_ack_i, wbm_err_i,
      output dmmu_ack_o, dmmu_data_o, immu_ack_o, immu_data_o,
      output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
      output busy_o, bus_err_o
   );

   modport slave (
      output dmmu_req_i, dmmu_addr_i, immu_req_i, immu_addr_i,
      output wbm_dat_i, wbm_ack_i, wbm_err_i,
      input  dmmu_ack_o, dmmu_data_o, immu_ack_o, immu_data_o,
      input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o,
      input  busy_o, bus_err_o
   );
endinterface

// File: rtl/mor1kx_tlb_reload_bridge.sv
// Serves DMMU/IMMU TLB reload reads over a classic Wishbone master, round-robin
// arbitrated, with a bus watchdog that turns a hung or failed read into data 0.
module mor1kx_tlb_reload_bridge #(
   parameter int unsigned OPTION_OPERAND_WIDTH = 32,
   parameter int unsigned OPTION_TIMEOUT_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   mor1kx_tlb_reload_bridge_if.master bus
);
   localparam int unsigned DW = OPTION_OPERAND_WIDTH;
   localparam int unsigned TW = OPTION_TIMEOUT_WIDTH;
   // Last count value of a live bus cycle; the cycle holding it is the expiry cycle
   localparam logic [TW-1:0] WDOG_LAST = {TW{1'b1}} - TW'(1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t          state_q, state_d;
   logic            grant_q, grant_d;   // 1: IMMU owns the current walk
   logic            last_q, last_d;     // 1: IMMU was granted most recently
   logic            drop_q, drop_d;     // granted client let go of req during BUS
   logic [TW-1:0]   wdog_q, wdog_d;
   logic [DW-1:0]   adr_q, adr_d;
   logic            cyc_q, cyc_d;
   logic            dmmu_ack_q, dmmu_ack_d;
   logic            immu_ack_q, immu_ack_d;
   logic [DW-1:0]   dmmu_data_q, dmmu_data_d;
   logic [DW-1:0]   immu_data_q, immu_data_d;
   logic            busy_q, busy_d;
   logic            bus_err_q, bus_err_d;
   logic            live;
   logic            finish;
   logic [DW-1:0]   rdata;

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      drop_d      = drop_q;
      wdog_d      = wdog_q;
      adr_d       = adr_q;
      cyc_d       = cyc_q;
      dmmu_ack_d  = 1'b0;
      immu_ack_d  = 1'b0;
      dmmu_data_d = '0;
      immu_data_d = '0;
      bus_err_d   = 1'b0;
      live        = 1'b0;
      finish      = 1'b0;
      rdata       = '0;

      case (state_q)
         IDLE: begin
            if (bus.dmmu_req_i || bus.immu_req_i) begin
               grant_d = (bus.dmmu_req_i && bus.immu_req_i) ? ~last_q : bus.immu_req_i;
               last_d  = grant_d;
               adr_d   = grant_d ? bus.immu_addr_i : bus.dmmu_addr_i;
               cyc_d   = 1'b1;
               wdog_d  = '0;
               drop_d  = 1'b0;
               state_d = BUS;
            end
         end
         BUS: begin
            live   = grant_q ? bus.immu_req_i : bus.dmmu_req_i;
            drop_d = drop_q || !live;
            wdog_d = wdog_q + TW'(1);
            // A slave ack in the expiry cycle still delivers real data
            if (bus.wbm_ack_i) begin
               finish = 1'b1;
               rdata  = bus.wbm_dat_i;
            end else if (bus.wbm_err_i || (wdog_q == WDOG_LAST)) begin
               finish    = 1'b1;
               bus_err_d = 1'b1;
            end
            if (finish) begin
               cyc_d   = 1'b0;
               state_d = RESP;
               if (!drop_d) begin
                  if (grant_q) begin
                     immu_ack_d  = 1'b1;
                     immu_data_d = rdata;
                  end else begin
                     dmmu_ack_d  = 1'b1;
                     dmmu_data_d = rdata;
                  end
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;
         drop_q      <= 1'b0;
         wdog_q      <= '0;
         adr_q       <= '0;
         cyc_q       <= 1'b0;
         dmmu_ack_q  <= 1'b0;
         immu_ack_q  <= 1'b0;
         dmmu_data_q <= '0;
         immu_data_q <= '0;
         busy_q      <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         drop_q      <= drop_d;
         wdog_q      <= wdog_d;
         adr_q       <= adr_d;
         cyc_q       <= cyc_d;
         dmmu_ack_q  <= dmmu_ack_d;
         immu_ack_q  <= immu_ack_d;
         dmmu_data_q <= dmmu_data_d;
         immu_data_q <= immu_data_d;
         busy_q      <= busy_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.wbm_adr_o   = adr_q;
   assign bus.wbm_cyc_o   = cyc_q;
   assign bus.wbm_stb_o   = cyc_q;
   assign bus.wbm_we_o    = 1'b0;
   assign bus.wbm_sel_o   = 4'hf;
   assign bus.wbm_cti_o   = 3'b000;
   assign bus.wbm_bte_o   = 2'b00;
   assign bus.dmmu_ack_o  = dmmu_ack_q;
   assign bus.immu_ack_o  = immu_ack_q;
   assign bus.dmmu_data_o = dmmu_data_q;
   assign bus.immu_data_o = immu_data_q;
   assign bus.busy_o      = busy_q;
   assign bus.bus_err_o   = bus_err_q;
endmodule
